one_unit_acc: RTL
=================

ONE_UNIT_ACC -- requirements
Module: one_unit_acc

Interface
REQ-001 SHALL have parameter LOG_N, default 8, meaning log2 of samples averaged per run (legal 1..12).
REQ-002 SHALL have clk_acc  input  1  rising-edge clock (only clock).
REQ-003 SHALL have rst_n_acc  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have start  input  1  begin a new averaging run (honoured in IDLE only).
REQ-005 SHALL have in_valid  input  1  zw1..zw4 carry a product sample.
REQ-006 SHALL have in_ready  output  1  block accepts a sample this cycle.
REQ-007 SHALL have zw1, zw2, zw3, zw4  input  26 each  signed Q12.13 products from the multiplier stage.
REQ-008 SHALL have out_valid  output  1  mean1..mean4 valid.
REQ-009 SHALL have out_ready  input  1  consumer takes the means.
REQ-010 SHALL have mean1, mean2, mean3, mean4  output  26 each  signed Q12.13 rounded means.
REQ-011 SHALL have busy  output  1  high in ACC or OUT.

Function
REQ-012 SHALL implement FSM states IDLE, ACC, OUT; reset state IDLE.
REQ-013 IDLE: in_ready=0, out_valid=0; start=1 clears four accumulators and sample counter, next state ACC.
REQ-014 ACC: in_ready=1; beat accepted only when in_valid && in_ready; each accepted beat adds sign-extended zw_i to acc_i and increments counter.
REQ-015 Accumulators SHALL be 26+LOG_N bits signed; no overflow possible; counter LOG_N+1 bits.
REQ-016 On acceptance of beat number 2^LOG_N, SHALL register mean_i = (acc_i_final + 2^(LOG_N-1)) >>> LOG_N (round half up, arithmetic shift) and enter OUT; out_valid high the next cycle.
REQ-017 Rounded result is bounded by the input range; SHALL be truncated to 26 bits with no saturation logic.
REQ-018 OUT: in_ready=0; out_valid=1; mean1..mean4 stable until out_valid && out_ready, then IDLE next cycle.
REQ-019 start SHALL be ignored in ACC and OUT, including the cycle of the OUT handshake.
REQ-020 in_valid SHALL be ignored whenever in_ready=0; gaps in in_valid SHALL not affect the count.
REQ-021 mean1..mean4 SHALL hold last result in IDLE until the next run's result is registered.

Reset
REQ-022 rst_n_acc low SHALL immediately force IDLE, accumulators=0, counter=0, mean1..mean4=0, out_valid=0, in_ready=0, busy=0.
REQ-023 Reset mid-run SHALL discard partial sums; next run after start contains only new beats.

Structure
REQ-024 Shared package fastica_pkg SHALL hold DATA_W=26, FRAC_W=13, and the FSM state type.
REQ-025 One sub-module one_unit_acc_lane (single accumulator + rounding) SHALL be instantiated four times; FSM and counter live in the top.

Verification
REQ-026 LOG_N=2, start, four beats zw_i=8192 -> out_valid 1 cycle after 4th accept, all means=8192.
REQ-027 LOG_N=2, zw1 beats 1,1,1,2 and zw2 beats -1,-1,-1,-2 -> mean1=1, mean2=-1 ((−5+2)>>>2).
REQ-028 LOG_N=2, four beats of 33554431 then of -33554432 (second run) -> means 33554431 then -33554432, no wrap.
REQ-029 in_valid pattern 1,0,0,1,0,1,1 (LOG_N=2) -> only 4 accepted; out_ready held low 5 cycles -> out_valid and means stable, in_ready=0, extra in_valid and start ignored.
REQ-030 rst_n_acc pulsed low after 2 accepted beats of 100 -> all outputs 0 asynchronously; new start plus four beats of 8 -> means=8.

Source files
------------

// File: rtl/fastica_pkg.sv
// Shared widths and accumulator-FSM state encoding for the FastICA datapath.
package fastica_pkg;

  localparam int unsigned DATA_W = 26;
  localparam int unsigned FRAC_W = 13;

  typedef logic [1:0] acc_state_t;

  localparam acc_state_t StIdle = 2'd0;
  localparam acc_state_t StAcc  = 2'd1;
  localparam acc_state_t StOut  = 2'd2;

endpackage

// File: rtl/one_unit_acc_lane.sv
// One accumulator lane: sums sign-extended Q12.13 samples and registers the rounded mean.
module one_unit_acc_lane
  import fastica_pkg::*;
#(
  parameter int unsigned LOG_N = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              add_i,
  input  logic              last_i,
  input  logic [DATA_W-1:0] zw_i,
  output logic [DATA_W-1:0] mean_o
);

  localparam int unsigned AccW = DATA_W + LOG_N;
  localparam logic [AccW-1:0] Rnd = AccW'(1) << (LOG_N - 1);

  logic [AccW-1:0]   acc_q, acc_d;
  logic [AccW-1:0]   sum;
  logic [AccW-1:0]   rnd;
  logic [DATA_W-1:0] mean_q, mean_d;
  logic              unused_rnd_lsbs;

  // The full sum plus half an LSB cannot leave AccW bits, so the mean is just a bit slice.
  always_comb begin
    sum    = acc_q + {{LOG_N{zw_i[DATA_W-1]}}, zw_i};
    rnd    = sum + Rnd;
    acc_d  = acc_q;
    mean_d = mean_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (add_i) begin
      acc_d = sum;
      if (last_i) begin
        mean_d = rnd[LOG_N +: DATA_W];
      end
    end
  end

  assign unused_rnd_lsbs = ^rnd[LOG_N-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      mean_q <= '0;
    end else begin
      acc_q  <= acc_d;
      mean_q <= mean_d;
    end
  end

  assign mean_o = mean_q;

endmodule

// File: rtl/one_unit_acc.sv
// Averages 2^LOG_N beats of four Q12.13 product streams into four rounded means.
module one_unit_acc
  import fastica_pkg::*;
#(
  parameter int unsigned LOG_N = 8
) (
  input  logic                     clk_acc,
  input  logic                     rst_n_acc,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] zw1,
  input  logic signed [DATA_W-1:0] zw2,
  input  logic signed [DATA_W-1:0] zw3,
  input  logic signed [DATA_W-1:0] zw4,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] mean1,
  output logic signed [DATA_W-1:0] mean2,
  output logic signed [DATA_W-1:0] mean3,
  output logic signed [DATA_W-1:0] mean4,
  output logic                     busy
);

  localparam int unsigned CntW = LOG_N + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'((1 << LOG_N) - 1);

  acc_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            clear;
  logic            accept;
  logic            last_beat;

  logic [DATA_W-1:0] zw_arr   [4];
  logic [DATA_W-1:0] mean_arr [4];

  assign in_ready  = (state_q == StAcc);
  assign out_valid = (state_q == StOut);
  assign busy      = (state_q != StIdle);
  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (cnt_q == LastCnt);

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          clear   = 1'b1;
          state_d = StAcc;
        end
      end
      StAcc: begin
        if (last_beat) state_d = StOut;
      end
      StOut: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_acc or negedge rst_n_acc) begin
    if (!rst_n_acc) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign zw_arr[0] = zw1;
  assign zw_arr[1] = zw2;
  assign zw_arr[2] = zw3;
  assign zw_arr[3] = zw4;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    one_unit_acc_lane #(
      .LOG_N(LOG_N)
    ) u_lane (
      .clk_i  (clk_acc),
      .rst_ni (rst_n_acc),
      .clear_i(clear),
      .add_i  (accept),
      .last_i (last_beat),
      .zw_i   (zw_arr[g]),
      .mean_o (mean_arr[g])
    );
  end

  assign mean1 = mean_arr[0];
  assign mean2 = mean_arr[1];
  assign mean3 = mean_arr[2];
  assign mean4 = mean_arr[3];

endmodule
